// File: rtl/gpu_cmd_pkg.sv
// Shared types and bus constants for the GPU host command front end.
package gpu_cmd_pkg;

    // Queue entries are sized for the widest bus this front end is built for.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    localparam logic [CMD_ADDR_W-1:0] GPU_ADDR_CONTROL = 32'h0000_0000;
    localparam logic [CMD_ADDR_W-1:0] GPU_ADDR_STATUS  = 32'h0000_0004;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'd0,
        OP_KICK      = 2'd1,
        OP_WAIT_IDLE = 2'd2,
        OP_READ      = 2'd3
    } cmd_op_t;

    typedef logic [2:0] cmd_state_t;
    localparam cmd_state_t ST_IDLE   = 3'd0;
    localparam cmd_state_t ST_EXEC   = 3'd1;
    localparam cmd_state_t ST_SETTLE = 3'd2;
    localparam cmd_state_t ST_POLL   = 3'd3;
    localparam cmd_state_t ST_RSP    = 3'd4;

    typedef struct packed {
        cmd_op_t                op;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/gpu_cmd_processor_cmd_queue.sv
// Circular FIFO of commands; full blocks pushes even when a pop happens in the same cycle.
module cmd_queue
    import gpu_cmd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     wr_entry,
    output cmd_t                     rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == COUNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_cmd_processor.sv
// Host command front end: turns queued commands into single-cycle GPU control-bus accesses.
module gpu_cmd_processor
    import gpu_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 16,
    parameter int KICK_SETTLE    = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_busy,
    output logic                  o_err,
    input  logic                  i_err_clr
);

    localparam int SETTLE_W = (KICK_SETTLE > 1) ? $clog2(KICK_SETTLE) : 1;
    localparam int POLL_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    cmd_state_t                  state;
    cmd_t                        q_in;
    cmd_t                        q_head;
    cmd_t                        cmd_reg;
    logic                        q_full;
    logic                        q_empty;
    logic [$clog2(CMD_DEPTH):0]  q_count;
    logic                        pop;
    logic                        timeout_hit;
    logic [SETTLE_W-1:0]         settle_cnt;
    logic [POLL_W-1:0]           poll_cnt;

    always_comb begin
        q_in      = '0;
        q_in.op   = cmd_op_t'(i_cmd_op);
        q_in.addr = CMD_ADDR_W'(i_cmd_addr);
        q_in.data = CMD_DATA_W'(i_cmd_data);
    end

    assign pop = (state == ST_IDLE) && !q_empty;

    cmd_queue #(
        .DEPTH (CMD_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (i_cmd_valid),
        .pop      (pop),
        .wr_entry (q_in),
        .rd_entry (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    assign o_cmd_ready = !q_full;
    assign o_busy      = (q_count != '0) || (state != ST_IDLE);
    assign o_rsp_valid = (state == ST_RSP);
    assign timeout_hit = (state == ST_POLL) && i_bus_rdata[0]
                         && (poll_cnt == POLL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (pop) begin
            cmd_reg <= q_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            poll_cnt   <= '0;
            o_err      <= 1'b0;
            o_rsp_data <= '0;
        end else begin
            // A timeout in the same cycle as a clear request leaves the error set.
            if (timeout_hit) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cmd_reg.op)
                        OP_WRITE: state <= ST_IDLE;
                        OP_KICK: begin
                            settle_cnt <= '0;
                            state      <= (KICK_SETTLE == 0) ? ST_IDLE : ST_SETTLE;
                        end
                        OP_WAIT_IDLE: begin
                            poll_cnt <= '0;
                            state    <= ST_POLL;
                        end
                        OP_READ: begin
                            o_rsp_data <= i_bus_rdata;
                            state      <= ST_RSP;
                        end
                    endcase
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_W'(KICK_SETTLE - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                ST_POLL: begin
                    if (!i_bus_rdata[0] || timeout_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                    end
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs are decoded from the FSM state, so we is only ever high in EXEC.
    always_comb begin
        o_bus_we    = 1'b0;
        o_bus_addr  = '0;
        o_bus_wdata = '0;
        case (state)
            ST_EXEC: begin
                case (cmd_reg.op)
                    OP_WRITE: begin
                        o_bus_we    = 1'b1;
                        o_bus_addr  = ADDR_WIDTH'(cmd_reg.addr);
                        o_bus_wdata = DATA_WIDTH'(cmd_reg.data);
                    end
                    OP_KICK: begin
                        o_bus_we    = 1'b1;
                        o_bus_addr  = ADDR_WIDTH'(GPU_ADDR_CONTROL);
                        o_bus_wdata = DATA_WIDTH'(1);
                    end
                    OP_READ: begin
                        o_bus_addr = ADDR_WIDTH'(cmd_reg.addr);
                    end
                    default: begin
                        o_bus_we = 1'b0;
                    end
                endcase
            end
            ST_POLL: begin
                o_bus_addr = ADDR_WIDTH'(GPU_ADDR_STATUS);
            end
            default: begin
                o_bus_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gpu_cmd_processor.sv
// Directed bench for gpu_cmd_processor: a default instance plus one with a short poll timeout.
module tb_gpu_cmd_processor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic        err;
    logic        err_clr = 1'b0;

    logic        t_cmd_valid = 1'b0;
    logic        t_cmd_ready;
    logic [1:0]  t_cmd_op = 2'd0;
    logic [31:0] t_cmd_addr = '0;
    logic [31:0] t_cmd_data = '0;
    logic        t_bus_we;
    logic [31:0] t_bus_addr;
    logic [31:0] t_bus_wdata;
    logic [31:0] t_bus_rdata;
    logic        t_rsp_valid;
    logic [31:0] t_rsp_data;
    logic        t_busy;
    logic        t_err;
    logic        t_err_clr = 1'b0;

    logic        stall_busy = 1'b0;
    logic        kick_busy;
    int          kick_age = 0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wa [20];
    logic [31:0] wd [20];
    int          wcyc [20];
    int          wcnt;
    int          polls;

    always #5 clk = ~clk;

    gpu_cmd_processor dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .i_bus_rdata (bus_rdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy),
        .o_err       (err),
        .i_err_clr   (err_clr)
    );

    gpu_cmd_processor #(
        .TIMEOUT_CYCLES (8)
    ) dut_to (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (t_cmd_valid),
        .o_cmd_ready (t_cmd_ready),
        .i_cmd_op    (t_cmd_op),
        .i_cmd_addr  (t_cmd_addr),
        .i_cmd_data  (t_cmd_data),
        .o_bus_we    (t_bus_we),
        .o_bus_addr  (t_bus_addr),
        .o_bus_wdata (t_bus_wdata),
        .i_bus_rdata (t_bus_rdata),
        .o_rsp_valid (t_rsp_valid),
        .i_rsp_ready (1'b1),
        .o_rsp_data  (t_rsp_data),
        .o_busy      (t_busy),
        .o_err       (t_err),
        .i_err_clr   (t_err_clr)
    );

    // GPU model: pipeline busy for ten cycles starting two cycles after a KICK write.
    always @(posedge clk) begin
        if (bus_we && bus_addr == 32'h0 && bus_wdata == 32'h1) begin
            kick_age <= 1;
        end else if (kick_age != 0 && kick_age < 1000) begin
            kick_age <= kick_age + 1;
        end
    end

    assign kick_busy = (kick_age >= 2) && (kick_age <= 11);

    always_comb begin
        if (bus_addr == 32'h4) begin
            bus_rdata = {31'b0, stall_busy | kick_busy};
        end else if (bus_addr == 32'hC) begin
            bus_rdata = 32'h30;
        end else begin
            bus_rdata = 32'hDEAD_0000;
        end
    end

    assign t_bus_rdata = (t_bus_addr == 32'h4) ? 32'h1 : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic t_push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        t_cmd_valid = 1'b1;
        t_cmd_op    = op;
        t_cmd_addr  = addr;
        t_cmd_data  = data;
        tick();
        t_cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_we", bus_we, 1'b0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_t_busy", t_busy, 1'b0);
        check("rst_t_rsp_valid", t_rsp_valid, 1'b0);
        check("rst_t_rsp_data", t_rsp_data, 32'h0);
        rst = 1'b0;
        tick();

        // Single WRITE: bus write exactly at N+2, busy gone at N+3
        push(2'd0, 32'h8, 32'h1234);
        check("wr_n1_we", bus_we, 1'b0);
        check("wr_n1_busy", busy, 1'b1);
        tick();
        check("wr_n2_we", bus_we, 1'b1);
        check("wr_n2_addr", bus_addr, 32'h8);
        check("wr_n2_wdata", bus_wdata, 32'h1234);
        tick();
        check("wr_n3_we", bus_we, 1'b0);
        check("wr_n3_busy", busy, 1'b0);
        tick();

        // KICK then WAIT_IDLE
        push(2'd1, 32'h0, 32'h0);
        push(2'd2, 32'h0, 32'h0);
        check("kick_we", bus_we, 1'b1);
        check("kick_addr", bus_addr, 32'h0);
        check("kick_wdata", bus_wdata, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("settle_we", bus_we, 1'b0);
            check("settle_addr", bus_addr, 32'h0);
        end
        tick();
        check("kick_idle_addr", bus_addr, 32'h0);
        tick();
        check("wait_exec_we", bus_we, 1'b0);
        check("wait_exec_addr", bus_addr, 32'h0);
        tick();
        polls = 0;
        while (bus_addr == 32'h4 && polls < 40) begin
            check("poll_we", bus_we, 1'b0);
            polls++;
            tick();
        end
        check("poll_cycles", polls, 7);
        check("poll_done_addr", bus_addr, 32'h0);
        check("poll_done_busy", busy, 1'b0);
        tick();

        // Fill the queue behind a stalled WAIT_IDLE
        stall_busy = 1'b1;
        push(2'd2, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            check("fill_ready", cmd_ready, 1'b1);
            push(2'd0, 32'h100 + i, i);
        end
        check("full_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_addr  = 32'h1FF;
        cmd_data  = 32'hBAD;
        tick();
        cmd_valid = 1'b0;
        check("full_ready_hold", cmd_ready, 1'b0);
        check("full_polling", bus_addr, 32'h4);
        stall_busy = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus_we && wcnt < 20) begin
                wa[wcnt]   = bus_addr;
                wd[wcnt]   = bus_wdata;
                wcyc[wcnt] = c;
                wcnt++;
            end
            tick();
        end
        check("drain_count", wcnt, 16);
        for (int i = 0; i < 16 && i < wcnt; i++) begin
            check("drain_addr", wa[i], 32'h100 + i);
            check("drain_data", wd[i], i);
            if (i > 0) begin
                check("drain_gap", wcyc[i] - wcyc[i-1], 2);
            end
        end
        check("drain_busy", busy, 1'b0);

        // READ with delayed response handshake, WRITE queued behind it
        push(2'd3, 32'hC, 32'h0);
        push(2'd0, 32'h40, 32'h77);
        check("rd_exec_addr", bus_addr, 32'hC);
        check("rd_exec_we", bus_we, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rsp_valid_hold", rsp_valid, 1'b1);
            check("rsp_data_hold", rsp_data, 32'h30);
            check("rsp_we", bus_we, 1'b0);
            check("rsp_addr", bus_addr, 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        check("rsp_valid_hs", rsp_valid, 1'b1);
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 1'b0);
        check("rsp_after_we", bus_we, 1'b0);
        tick();
        check("rd_next_we", bus_we, 1'b1);
        check("rd_next_addr", bus_addr, 32'h40);
        check("rd_next_wdata", bus_wdata, 32'h77);
        tick();

        // Reset while polling with commands queued
        stall_busy = 1'b1;
        push(2'd2, 32'h0, 32'h0);
        push(2'd0, 32'h200, 32'h1);
        push(2'd0, 32'h204, 32'h2);
        push(2'd0, 32'h208, 32'h3);
        check("pre_rst_addr", bus_addr, 32'h4);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_we", bus_we, 1'b0);
        check("mid_rst_addr", bus_addr, 32'h0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b1);
        stall_busy = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus_we) begin
                wcnt++;
            end
            tick();
        end
        check("mid_rst_no_writes", wcnt, 0);

        // WAIT_IDLE timeout on the short-timeout instance
        t_push(2'd2, 32'h0, 32'h0);
        t_push(2'd0, 32'h20, 32'h55);
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        check("to_last_poll_addr", t_bus_addr, 32'h4);
        check("to_last_poll_err", t_err, 1'b0);
        tick();
        check("to_err_set", t_err, 1'b1);
        check("to_idle_we", t_bus_we, 1'b0);
        tick();
        check("to_next_we", t_bus_we, 1'b1);
        check("to_next_addr", t_bus_addr, 32'h20);
        check("to_next_wdata", t_bus_wdata, 32'h55);
        t_err_clr = 1'b1;
        tick();
        t_err_clr = 1'b0;
        check("to_err_clr", t_err, 1'b0);
        tick();

        // Timeout coinciding with a clear request: error ends up set
        t_err_clr = 1'b1;
        t_push(2'd2, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        check("to2_err_before", t_err, 1'b0);
        tick();
        check("to2_set_wins", t_err, 1'b1);
        t_err_clr = 1'b0;
        tick();
        check("to2_sticky", t_err, 1'b1);
        t_err_clr = 1'b1;
        tick();
        t_err_clr = 1'b0;
        check("to2_cleared", t_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
